// File: rtl/cabin_pkg.sv
// cabin_pkg: phase codes, fault codes and qualifier state encoding shared by the cabin logic
package cabin_pkg;
  typedef enum logic [2:0] {
    PH_GROUND   = 3'b000,
    PH_TAXI     = 3'b001,
    PH_TAKEOFF  = 3'b010,
    PH_CLIMB    = 3'b011,
    PH_CRUISE   = 3'b100,
    PH_DESCENT  = 3'b101,
    PH_LANDING  = 3'b110,
    PH_INVALID  = 3'b111
  } phase_e;
  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_INVALID = 2'b01,
    FC_ILLEGAL = 2'b10,
    FC_TIMEOUT = 2'b11
  } fault_e;
  typedef enum logic [1:0] {
    Q_INIT     = 2'b00,
    Q_STABLE   = 2'b01,
    Q_SETTLING = 2'b10,
    Q_FAULT    = 2'b11
  } qstate_e;
endpackage

// File: rtl/phase_transition_checker.sv
// phase_transition_checker: flags whether cur_phase -> cand_phase is a permitted flight-phase step
module phase_transition_checker
  import cabin_pkg::*;
(
  input  logic [2:0] cur_phase,
  input  logic [2:0] cand_phase,
  output logic       legal,
  output logic       invalid
);
  logic [5:0] pair;
  assign pair    = {cur_phase, cand_phase};
  assign invalid = cand_phase == PH_INVALID;
  // octal pairs read as {from, to}; 53 and 63 are the go-arounds
  assign legal   = !invalid && (cur_phase == cand_phase ||
                   pair inside {6'o01, 6'o12, 6'o23, 6'o34, 6'o45, 6'o56, 6'o10, 6'o61, 6'o53, 6'o63});
endmodule

// File: rtl/flight_phase_qualifier.sv
// flight_phase_qualifier: debounces the raw avionics phase and enforces the legal phase sequence
module flight_phase_qualifier
  import cabin_pkg::*;
#(
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 4,
  parameter int FAULT_TIMEOUT = 64,
  parameter int TO_W          = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       raw_valid,
  input  logic [2:0] raw_phase,
  input  logic       fault_clear,
  output logic [2:0] flight_phase,
  output logic       phase_stable,
  output logic       phase_fault,
  output logic [1:0] fault_code
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(FAULT_TIMEOUT);
  qstate_e          state_q, state_d;
  logic [2:0]       cand_q, cand_d, phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [1:0]       code_q, code_d;
  logic             stable_q, stable_d, fault_q, fault_d;
  logic             sample, qualify, legal, invalid;

  phase_transition_checker u_chk (
    .cur_phase  (phase_q),
    .cand_phase (raw_phase),
    .legal      (legal),
    .invalid    (invalid)
  );

  always_comb begin
    sample   = en && raw_valid;
    cand_d   = sample ? raw_phase : cand_q;
    cnt_d    = !sample ? cnt_q : raw_phase != cand_q ? CNT_W'(1) : cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1;
    qualify  = sample && cnt_d == CNT_MAX && cnt_q != CNT_MAX;
    state_d  = state_q;
    phase_d  = phase_q;
    code_d   = code_q;
    to_cnt_d = to_cnt_q;
    if (en)
      case (state_q)
        Q_INIT:
          if (qualify) begin
            state_d = invalid ? Q_FAULT : Q_STABLE;
            code_d  = invalid ? FC_INVALID : code_q;
            phase_d = invalid ? phase_q : raw_phase;
          end
        Q_STABLE:
          if (sample && raw_phase != phase_q) state_d = Q_SETTLING;
        Q_SETTLING: begin
          to_cnt_d = to_cnt_q + 1'b1;
          // a qualify takes priority over a timeout landing on the same edge
          if (qualify) begin
            state_d  = legal ? Q_STABLE : Q_FAULT;
            code_d   = invalid ? FC_INVALID : legal ? code_q : FC_ILLEGAL;
            phase_d  = legal ? raw_phase : phase_q;
            to_cnt_d = '0;
          end else if (to_cnt_d == TO_MAX) begin
            state_d  = Q_FAULT;
            code_d   = FC_TIMEOUT;
            to_cnt_d = '0;
          end
        end
        default:
          if (fault_clear) begin
            state_d = Q_INIT;
            code_d  = FC_NONE;
            cnt_d   = '0;
          end
      endcase
    stable_d = state_d == Q_STABLE;
    fault_d  = state_d == Q_FAULT;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q  <= Q_INIT;
      cand_q   <= '0;
      cnt_q    <= '0;
      to_cnt_q <= '0;
      phase_q  <= '0;
      code_q   <= '0;
      stable_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      to_cnt_q <= to_cnt_d;
      phase_q  <= phase_d;
      code_q   <= code_d;
      stable_q <= stable_d;
      fault_q  <= fault_d;
    end

  assign flight_phase = phase_q;
  assign phase_stable = stable_q;
  assign phase_fault  = fault_q;
  assign fault_code   = code_q;
endmodule

// File: tb/tb_flight_phase_qualifier.sv
// tb_flight_phase_qualifier: directed scoreboard bench for flight_phase_qualifier
module tb_flight_phase_qualifier;
  typedef struct packed {
    logic [2:0] ph;
    logic       st;
    logic       fl;
    logic [1:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       raw_valid = 1'b0;
  logic [2:0] raw_phase = 3'b000;
  logic       fault_clear = 1'b0;
  logic [2:0] flight_phase;
  logic       phase_stable, phase_fault;
  logic [1:0] fault_code;
  int         tests = 0;
  int         fails = 0;
  exp_t       sb[$];
  string      tq[$];

  flight_phase_qualifier dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .raw_valid    (raw_valid),
    .raw_phase    (raw_phase),
    .fault_clear  (fault_clear),
    .flight_phase (flight_phase),
    .phase_stable (phase_stable),
    .phase_fault  (phase_fault),
    .fault_code   (fault_code)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(input logic [2:0] ph, input logic st, input logic fl, input logic [1:0] fc);
    exp_t x;
    x.ph = ph;
    x.st = st;
    x.fl = fl;
    x.fc = fc;
    return x;
  endfunction

  task automatic compare(input string tag, input exp_t x);
    tests++;
    assert (flight_phase === x.ph) else begin
      fails++;
      $error("FAIL %s flight_phase got %b exp %b", tag, flight_phase, x.ph);
    end
    tests++;
    assert (phase_stable === x.st) else begin
      fails++;
      $error("FAIL %s phase_stable got %b exp %b", tag, phase_stable, x.st);
    end
    tests++;
    assert (phase_fault === x.fl) else begin
      fails++;
      $error("FAIL %s phase_fault got %b exp %b", tag, phase_fault, x.fl);
    end
    tests++;
    assert (fault_code === x.fc) else begin
      fails++;
      $error("FAIL %s fault_code got %b exp %b", tag, fault_code, x.fc);
    end
  endtask

  task automatic drain;
    while (sb.size() > 0) compare(tq.pop_front(), sb.pop_front());
  endtask

  task automatic step(input logic e, input logic v, input logic [2:0] ph, input logic clr,
                      input bit chk, input string tag, input exp_t x);
    en = e;
    raw_valid = v;
    raw_phase = ph;
    fault_clear = clr;
    if (chk) begin
      sb.push_back(x);
      tq.push_back(tag);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic hold(input logic [2:0] ph, input int n, input string tag, input exp_t x);
    for (int i = 0; i < n - 1; i++) step(1'b1, 1'b1, ph, 1'b0, 1'b0, "", x);
    step(1'b1, 1'b1, ph, 1'b0, 1'b1, tag, x);
  endtask

  initial begin
    logic [2:0] walk [5];
    walk = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd3};
    #3;
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, "reset", ex(3'd0, 1'b0, 1'b0, 2'd0));
    reset_n = 1'b1;
    hold(3'd0, 7, "ground_edge7", ex(3'd0, 1'b0, 1'b0, 2'd0));
    hold(3'd0, 1, "ground_edge8", ex(3'd0, 1'b1, 1'b0, 2'd0));
    hold(3'd1, 1, "taxi_first", ex(3'd0, 1'b0, 1'b0, 2'd0));
    hold(3'd1, 7, "taxi_qual", ex(3'd1, 1'b1, 1'b0, 2'd0));
    hold(3'd2, 1, "glitch_first", ex(3'd1, 1'b0, 1'b0, 2'd0));
    hold(3'd2, 2, "glitch_hold", ex(3'd1, 1'b0, 1'b0, 2'd0));
    hold(3'd1, 7, "glitch_back7", ex(3'd1, 1'b0, 1'b0, 2'd0));
    hold(3'd1, 1, "glitch_back8", ex(3'd1, 1'b1, 1'b0, 2'd0));
    foreach (walk[i]) hold(walk[i], 8, $sformatf("walk_%0d", walk[i]), ex(walk[i], 1'b1, 1'b0, 2'd0));
    step(1'b1, 1'b1, 3'd4, 1'b0, 1'b1, "to_enter", ex(3'd3, 1'b0, 1'b0, 2'd0));
    for (int i = 1; i < 63; i++) step(1'b1, 1'b1, (i % 2) ? 3'd3 : 3'd4, 1'b0, 1'b0, "", '0);
    step(1'b1, 1'b1, 3'd3, 1'b0, 1'b1, "to_63", ex(3'd3, 1'b0, 1'b0, 2'd0));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, "", '0);
    step(1'b0, 1'b1, 3'd3, 1'b0, 1'b1, "to_frozen", ex(3'd3, 1'b0, 1'b0, 2'd0));
    step(1'b1, 1'b1, 3'd4, 1'b0, 1'b1, "to_64", ex(3'd3, 1'b0, 1'b1, 2'd3));
    step(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, "clear_to", ex(3'd3, 1'b0, 1'b0, 2'd0));
    hold(3'd0, 8, "init_ground", ex(3'd0, 1'b1, 1'b0, 2'd0));
    hold(3'd4, 8, "illegal", ex(3'd0, 1'b0, 1'b1, 2'd2));
    hold(3'd4, 3, "illegal_sticky", ex(3'd0, 1'b0, 1'b1, 2'd2));
    step(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, "clear_ill", ex(3'd0, 1'b0, 1'b0, 2'd0));
    hold(3'd4, 7, "cruise_edge7", ex(3'd0, 1'b0, 1'b0, 2'd0));
    hold(3'd4, 1, "cruise_edge8", ex(3'd4, 1'b1, 1'b0, 2'd0));
    step(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, "clear_noop", ex(3'd4, 1'b1, 1'b0, 2'd0));
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, "en_freeze", ex(3'd4, 1'b1, 1'b0, 2'd0));
    reset_n = 1'b0;
    #2;
    sb.push_back(ex(3'd0, 1'b0, 1'b0, 2'd0));
    tq.push_back("async_reset");
    drain();
    step(1'b1, 1'b1, 3'd7, 1'b0, 1'b0, "", '0);
    reset_n = 1'b1;
    hold(3'd7, 7, "invalid_edge7", ex(3'd0, 1'b0, 1'b0, 2'd0));
    step(1'b1, 1'b1, 3'd7, 1'b1, 1'b1, "invalid_vs_clear", ex(3'd0, 1'b0, 1'b1, 2'd1));
    step(1'b1, 1'b1, 3'd7, 1'b0, 1'b1, "invalid_sticky", ex(3'd0, 1'b0, 1'b1, 2'd1));
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, "clear_en_low", ex(3'd0, 1'b0, 1'b1, 2'd1));
    step(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, "clear_inv", ex(3'd0, 1'b0, 1'b0, 2'd0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/flight_phase_qualifier.md
# flight_phase_qualifier

Qualifies the raw 3-bit flight-phase code from avionics before it reaches the cabin phase FSM. It debounces the raw phase by requiring `STABLE_CYCLES` consecutive identical samples. It checks every qualified change against the permitted flight-phase sequence and raises a sticky fault on illegal or invalid phases and on prolonged instability. Its outputs `flight_phase` and `phase_stable` drive the cabin FSM directly, and `phase_fault` is ORed into that FSM's `fault_detected`.

## Interface
- `STABLE_CYCLES`, default 8: consecutive identical valid samples needed to qualify a phase (range 2..15).
- `CNT_W`, default 4: sample-counter width; must satisfy 2^CNT_W > `STABLE_CYCLES`.
- `FAULT_TIMEOUT`, default 64: maximum number of `en` cycles spent in SETTLING before a timeout fault.
- `TO_W`, default 7: timeout-counter width; must satisfy 2^TO_W > `FAULT_TIMEOUT`.

- `clk`  in  1  single clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  0 freezes every register; `fault_clear` is ignored while 0.
- `raw_valid`  in  1  sample strobe; `raw_phase` is sampled only when this is 1.
- `raw_phase`  in  3  unqualified phase code.
- `fault_clear`  in  1  one-cycle pulse that releases FAULT.
- `flight_phase`  out  3  last qualified phase; reset value 000.
- `phase_stable`  out  1  1 only in STABLE; reset value 0.
- `phase_fault`  out  1  sticky fault flag; reset value 0.
- `fault_code`  out  2  fault cause: 00 none, 01 invalid code 111, 10 illegal transition, 11 settle timeout; reset value 00.

## Operation
- Internal state: candidate `cand` (reset 000), sample count `cnt` (reset 0), timeout count `to_cnt` (reset 0).
- State register: INIT, STABLE, SETTLING, FAULT. Reset state is INIT.
- Sample rule, applied when `en` and `raw_valid` are both 1:
  - if `raw_phase` equals `cand`, `cnt` increments and saturates at `STABLE_CYCLES`;
  - otherwise `cand` loads `raw_phase` and `cnt` loads 1.
- Qualify event: the sample that makes `cnt` equal `STABLE_CYCLES`. While `cnt` stays saturated, no further qualify events occur.
- INIT: accepts any qualified code 000..110. It loads `flight_phase` and moves to STABLE. A qualified 111 moves to FAULT with code 01. No timeout runs in INIT.
- STABLE: a sample that differs from `flight_phase` moves to SETTLING. `flight_phase` is held.
- SETTLING: `to_cnt` increments on every `en` cycle.
  - Qualify of a code equal to `flight_phase` returns to STABLE.
  - Qualify of a legal new code loads `flight_phase` and moves to STABLE.
  - Qualify of an illegal code moves to FAULT with code 10.
  - Qualify of 111 moves to FAULT with code 01.
  - `to_cnt` reaching `FAULT_TIMEOUT` moves to FAULT with code 11.
  - `to_cnt` clears on every exit from SETTLING.
- Legal transitions: any code to itself, plus 000→001, 001→010, 010→011, 011→100, 100→101, 101→110, 001→000, 110→001, 101→011 (go-around), 110→011 (go-around). Everything else is illegal.
- FAULT:
  - `phase_stable` is 0, `phase_fault` is 1, `flight_phase` is held.
  - Sampling continues.
  - `fault_clear` with `en` high moves to INIT, clears `fault_code`, and clears `cnt`.
- Simultaneous events:
  - A new fault in the same cycle as `fault_clear`: the fault wins and `fault_code` updates.
  - Qualify in the same cycle that the timeout is reached: the qualify wins.
  - `fault_clear` outside FAULT has no effect.
- Reset mid-operation immediately returns every register to its reset value.

## Timing
- All outputs are registered.
- A qualifying sample presented before edge k updates `flight_phase` and `phase_stable` after edge k.
- With `raw_valid` held high, a new phase is stable `STABLE_CYCLES` edges after its first sample.
- `phase_stable` falls on the edge that captures the first differing sample.
- The timeout fault asserts on the edge where `to_cnt` reaches `FAULT_TIMEOUT`.

## Structure
- Shared package `cabin_pkg`:
  - phase codes PH_GROUND..PH_LANDING and PH_INVALID = 3'b111;
  - fault codes FC_NONE / FC_INVALID / FC_ILLEGAL / FC_TIMEOUT;
  - qualifier state encoding.
- Sub-module `phase_transition_checker`: combinational; inputs current phase and candidate phase; outputs `legal` and `invalid`.

## Test plan
- Reset, then `raw_phase`=000 with `raw_valid`=1 for 8 cycles → `phase_stable`=1 after edge 8, `flight_phase`=000; at edge 7, `phase_stable` is still 0.
- In STABLE at 001, drive 010 for 3 samples, then 001 for 8 samples → SETTLING, then STABLE at 001; `flight_phase` never changes.
- Walk 000→001→010→011→100→101→011 (go-around) with 8 samples each → every phase qualifies and `phase_fault` stays 0.
- From 000, drive 100 for 8 samples → `phase_fault`=1, `fault_code`=10, `flight_phase`=000; then `fault_clear` followed by 100 for 8 samples → STABLE at 100.
- Toggle `raw_phase` 011/100 every cycle for 64 cycles from STABLE → `fault_code`=11 at the 64th SETTLING cycle; `en`=0 during the toggle freezes `to_cnt`.
- Drive 111 for 8 samples from INIT → `fault_code`=01; `fault_clear` in the same cycle as a new fault → the fault is retained.
